// File: rtl/cp0_pkg.sv
// rtl/cp0_pkg.sv - shared CP0 register numbers, exception codes and redirect encodings
package cp0_pkg;

    localparam logic [4:0] CP0_STATUS = 5'd12;
    localparam logic [4:0] CP0_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_EPC    = 5'd14;

    localparam logic [4:0] EXC_INT = 5'd0;
    localparam logic [4:0] EXC_RI  = 5'd10;
    localparam logic [4:0] EXC_OV  = 5'd12;

    localparam logic [1:0] PCSEL_NORMAL  = 2'd0;
    localparam logic [1:0] PCSEL_HANDLER = 2'd1;
    localparam logic [1:0] PCSEL_EPC     = 2'd2;

    // The control state is exactly Status.EXL, so the encoding is fixed to it.
    typedef enum logic {
        ST_NORMAL     = 1'b0,
        ST_IN_HANDLER = 1'b1
    } cp0_state_t;

    // Cause as seen by mfc0: IP2 at bit 10, ExcCode at bits 6:2.
    function automatic logic [31:0] cause_word(input logic ip2, input logic [4:0] code);
        return {21'd0, ip2, 3'd0, code, 2'b00};
    endfunction

endpackage

// File: rtl/sync_flops.sv
// rtl/sync_flops.sv - multi-flop synchronizer for the external interrupt level
module sync_flops #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] r_sync;

    // Shift the asynchronous level through DEPTH flops; the last one is safe to use.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[DEPTH-2:0], d};
        end
    end

    assign q = r_sync[DEPTH-1];

endmodule

// File: rtl/exception_ctrl.sv
// rtl/exception_ctrl.sv - CP0 exception controller: Status/Cause/EPC, flushes and PC redirect
module exception_ctrl
    import cp0_pkg::*;
#(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_0180,
    parameter int          SYNC_STAGES  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        IntReq,
    input  logic        Overflow_E,
    input  logic        Undefined_D,
    input  logic        Eret_D,
    input  logic        Stall_D,
    input  logic [31:0] PC_D,
    input  logic [31:0] PC_E,
    input  logic [4:0]  Cp0Addr_D,
    input  logic        Mtc0_W,
    input  logic [4:0]  Cp0Addr_W,
    input  logic [31:0] Cp0Wdata_W,
    output logic        Flush_D,
    output logic        Flush_E,
    output logic        Flush_M,
    output logic [1:0]  PCSel_Exc,
    output logic [31:0] ExcPC,
    output logic [31:0] Cp0Rdata_D,
    output logic        Exl
);

    logic        w_ip2;
    cp0_state_t  r_state;
    cp0_state_t  w_state_next;
    logic        r_ie;
    logic [4:0]  r_exccode;
    logic [31:0] r_epc;
    logic        w_exl;

    logic        w_take_ov;
    logic        w_take_ri;
    logic        w_take_int;
    logic        w_take_eret;
    logic        w_entry;
    logic [4:0]  w_entry_code;
    logic [31:0] w_entry_pc;
    logic        w_wr_status;
    logic        w_wr_cause;
    logic        w_wr_epc;
    logic [31:0] w_epc_fwd;
    logic [31:0] w_rdata;

    sync_flops #(.DEPTH(SYNC_STAGES)) u_int_sync (
        .clk (clk),
        .rst (rst),
        .d   (IntReq),
        .q   (w_ip2)
    );

    assign w_exl = (r_state == ST_IN_HANDLER);

    // Resolve which single event is taken this cycle, highest priority first.
    always_comb begin
        w_take_ov    = Overflow_E;
        w_take_ri    = Undefined_D && !Stall_D && !w_take_ov;
        w_take_int   = w_ip2 && r_ie && !w_exl && !Stall_D && !w_take_ov && !Undefined_D;
        w_take_eret  = Eret_D && !Stall_D && !w_take_ov && !w_take_ri && !w_take_int;
        w_entry      = w_take_ov || w_take_ri || w_take_int;
        w_entry_code = EXC_INT;
        w_entry_pc   = PC_D;
        if (w_take_ov) begin
            w_entry_code = EXC_OV;
            w_entry_pc   = PC_E;
        end else if (w_take_ri) begin
            w_entry_code = EXC_RI;
        end
        w_wr_status  = Mtc0_W && (Cp0Addr_W == CP0_STATUS);
        w_wr_cause   = Mtc0_W && (Cp0Addr_W == CP0_CAUSE);
        w_wr_epc     = Mtc0_W && (Cp0Addr_W == CP0_EPC);
        // An eret in Decode must see an EPC being written back in the same cycle.
        w_epc_fwd    = w_wr_epc ? Cp0Wdata_W : r_epc;
    end

    // Control state register (this is Status.EXL).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_NORMAL;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: entry beats eret, eret beats an mtc0 to Status.
    always_comb begin
        w_state_next = r_state;
        if (w_entry) begin
            w_state_next = ST_IN_HANDLER;
        end else if (w_take_eret) begin
            w_state_next = ST_NORMAL;
        end else if (w_wr_status) begin
            w_state_next = Cp0Wdata_W[1] ? ST_IN_HANDLER : ST_NORMAL;
        end
    end

    // IE, ExcCode and EPC; exception entry blocks mtc0 on ExcCode/EPC but not on IE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ie      <= 1'b0;
            r_exccode <= 5'd0;
            r_epc     <= 32'd0;
        end else begin
            if (w_wr_status) begin
                r_ie <= Cp0Wdata_W[0];
            end
            if (w_entry) begin
                r_exccode <= w_entry_code;
                if (!w_exl) begin
                    r_epc <= w_entry_pc;
                end
            end else begin
                if (w_wr_cause) begin
                    r_exccode <= Cp0Wdata_W[6:2];
                end
                if (w_wr_epc) begin
                    r_epc <= Cp0Wdata_W;
                end
            end
        end
    end

    // mfc0 read mux with bypass from the mtc0 in Writeback.
    always_comb begin
        w_rdata = 32'd0;
        if (Mtc0_W && (Cp0Addr_W == Cp0Addr_D)) begin
            w_rdata = Cp0Wdata_W;
        end else begin
            case (Cp0Addr_D)
                CP0_STATUS: w_rdata = {30'd0, w_exl, r_ie};
                CP0_CAUSE:  w_rdata = cause_word(w_ip2, r_exccode);
                CP0_EPC:    w_rdata = r_epc;
                default:    w_rdata = 32'd0;
            endcase
        end
    end

    // Pipeline-facing outputs, forced to their idle values while reset is held.
    always_comb begin
        Flush_D    = 1'b0;
        Flush_E    = 1'b0;
        Flush_M    = 1'b0;
        PCSel_Exc  = PCSEL_NORMAL;
        ExcPC      = 32'd0;
        Cp0Rdata_D = 32'd0;
        Exl        = 1'b0;
        if (!rst) begin
            Flush_D    = w_entry || w_take_eret;
            Flush_E    = w_entry;
            Flush_M    = w_take_ov;
            Cp0Rdata_D = w_rdata;
            Exl        = w_exl;
            if (w_entry) begin
                PCSel_Exc = PCSEL_HANDLER;
                ExcPC     = HANDLER_ADDR;
            end else if (w_take_eret) begin
                PCSel_Exc = PCSEL_EPC;
                ExcPC     = w_epc_fwd;
            end
        end
    end

endmodule

// File: tb/tb_exception_ctrl.sv
// tb/tb_exception_ctrl.sv - randomized and directed checks of exception_ctrl against a behavioural model
module tb_exception_ctrl;

    localparam int          SYNC    = 2;
    localparam logic [31:0] HANDLER = 32'h0000_0180;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        IntReq, Overflow_E, Undefined_D, Eret_D, Stall_D;
    logic [31:0] PC_D, PC_E;
    logic [4:0]  Cp0Addr_D;
    logic        Mtc0_W;
    logic [4:0]  Cp0Addr_W;
    logic [31:0] Cp0Wdata_W;
    logic        Flush_D, Flush_E, Flush_M;
    logic [1:0]  PCSel_Exc;
    logic [31:0] ExcPC;
    logic [31:0] Cp0Rdata_D;
    logic        Exl;

    exception_ctrl #(.HANDLER_ADDR(HANDLER), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .rst(rst), .IntReq(IntReq), .Overflow_E(Overflow_E),
        .Undefined_D(Undefined_D), .Eret_D(Eret_D), .Stall_D(Stall_D),
        .PC_D(PC_D), .PC_E(PC_E), .Cp0Addr_D(Cp0Addr_D), .Mtc0_W(Mtc0_W),
        .Cp0Addr_W(Cp0Addr_W), .Cp0Wdata_W(Cp0Wdata_W), .Flush_D(Flush_D),
        .Flush_E(Flush_E), .Flush_M(Flush_M), .PCSel_Exc(PCSel_Exc),
        .ExcPC(ExcPC), .Cp0Rdata_D(Cp0Rdata_D), .Exl(Exl)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Architectural model state
    bit          m_ie, m_exl;
    logic [4:0]  m_code;
    logic [31:0] m_epc;
    bit          int_hist[$];

    // DUT outputs as observed mid-cycle by the last step
    logic        obs_fd, obs_fe, obs_fm, obs_exl;
    logic [1:0]  obs_pcsel;
    logic [31:0] obs_excpc, obs_rdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ie   = 1'b0;
        m_exl  = 1'b0;
        m_code = 5'd0;
        m_epc  = 32'd0;
        int_hist.delete();
        for (int i = 0; i < SYNC; i++) int_hist.push_back(1'b0);
    endtask

    task automatic set_idle();
        IntReq      = 1'b0;
        Overflow_E  = 1'b0;
        Undefined_D = 1'b0;
        Eret_D      = 1'b0;
        Stall_D     = 1'b0;
        PC_D        = 32'd0;
        PC_E        = 32'd0;
        Cp0Addr_D   = 5'd0;
        Mtc0_W      = 1'b0;
        Cp0Addr_W   = 5'd0;
        Cp0Wdata_W  = 32'd0;
    endtask

    function automatic logic [31:0] model_read(input bit ip2);
        if (Mtc0_W && Cp0Addr_W == Cp0Addr_D) return Cp0Wdata_W;
        case (Cp0Addr_D)
            5'd12:   return {30'd0, m_exl, m_ie};
            5'd13:   return (32'(ip2) << 10) | (32'(m_code) << 2);
            5'd14:   return m_epc;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [4:0] pick_addr();
        int a;
        a = $urandom_range(0, 7);
        if (a < 3) return 5'(12 + a);
        return 5'($urandom_range(0, 31));
    endfunction

    // One clock cycle with the currently driven inputs: check at negedge, advance model at posedge.
    task automatic step();
        bit ip2, ov, ri, intr, er, entry, old_exl, dummy;
        logic [1:0]  e_pcsel;
        logic [31:0] e_excpc;
        @(negedge clk);
        ip2  = int_hist[SYNC-1];
        ov   = Overflow_E;
        ri   = !ov && Undefined_D && !Stall_D;
        intr = !ov && !ri && !Undefined_D && ip2 && m_ie && !m_exl && !Stall_D;
        er   = !ov && !ri && !intr && Eret_D && !Stall_D;
        entry = ov || ri || intr;
        e_pcsel = entry ? 2'd1 : (er ? 2'd2 : 2'd0);
        if (entry)   e_excpc = HANDLER;
        else if (er) e_excpc = (Mtc0_W && Cp0Addr_W == 5'd14) ? Cp0Wdata_W : m_epc;
        else         e_excpc = 32'd0;
        obs_fd = Flush_D; obs_fe = Flush_E; obs_fm = Flush_M; obs_exl = Exl;
        obs_pcsel = PCSel_Exc; obs_excpc = ExcPC; obs_rdata = Cp0Rdata_D;
        chk("flush_d", 32'(obs_fd), 32'(entry || er));
        chk("flush_e", 32'(obs_fe), 32'(entry));
        chk("flush_m", 32'(obs_fm), 32'(ov));
        chk("pcsel",   32'(obs_pcsel), 32'(e_pcsel));
        chk("excpc",   obs_excpc, e_excpc);
        chk("rdata",   obs_rdata, model_read(ip2));
        chk("exl",     32'(obs_exl), 32'(m_exl));
        @(posedge clk);
        old_exl = m_exl;
        if (Mtc0_W && Cp0Addr_W == 5'd12) begin
            m_ie  = Cp0Wdata_W[0];
            m_exl = Cp0Wdata_W[1];
        end
        if (!entry && Mtc0_W && Cp0Addr_W == 5'd13) m_code = Cp0Wdata_W[6:2];
        if (!entry && Mtc0_W && Cp0Addr_W == 5'd14) m_epc = Cp0Wdata_W;
        if (er) m_exl = 1'b0;
        if (entry) begin
            m_code = ov ? 5'd12 : (ri ? 5'd10 : 5'd0);
            if (!old_exl) m_epc = ov ? PC_E : PC_D;
            m_exl = 1'b1;
        end
        int_hist.push_front(IntReq);
        dummy = int_hist.pop_back();
        #1;
    endtask

    initial begin
        set_idle();
        model_reset();
        // Outputs stay idle during reset even with events asserted
        Overflow_E = 1'b1; Eret_D = 1'b1; Undefined_D = 1'b1;
        Mtc0_W = 1'b1; Cp0Addr_W = 5'd12; Cp0Addr_D = 5'd12; Cp0Wdata_W = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold_flush", {29'd0, Flush_D, Flush_E, Flush_M}, 32'd0);
        chk("rst_hold_pcsel", 32'(PCSel_Exc), 32'd0);
        chk("rst_hold_excpc", ExcPC, 32'd0);
        chk("rst_hold_rdata", Cp0Rdata_D, 32'd0);
        set_idle();
        rst = 1'b0;

        // Reset state read-back
        Cp0Addr_D = 5'd12; step(); chk("reset_status", obs_rdata, 32'd0);
        Cp0Addr_D = 5'd13; step(); chk("reset_cause",  obs_rdata, 32'd0);

        // Overflow entry
        set_idle(); Overflow_E = 1'b1; PC_E = 32'h0040_0010; step();
        chk("ov_flushes", {29'd0, obs_fd, obs_fe, obs_fm}, 32'd7);
        chk("ov_pcsel", 32'(obs_pcsel), 32'd1);
        chk("ov_excpc", obs_excpc, 32'h180);
        set_idle(); Cp0Addr_D = 5'd14; step();
        chk("ov_epc", obs_rdata, 32'h0040_0010);
        chk("ov_exl", 32'(obs_exl), 32'd1);
        Cp0Addr_D = 5'd13; step(); chk("ov_cause", obs_rdata, 32'h30);

        // Overflow beats Undefined; EPC kept because EXL=1
        set_idle(); Overflow_E = 1'b1; Undefined_D = 1'b1; PC_E = 32'h0040_0020; PC_D = 32'h0040_0024; step();
        chk("prio_flush_m", 32'(obs_fm), 32'd1);
        set_idle(); Cp0Addr_D = 5'd13; step(); chk("prio_cause", obs_rdata, 32'h30);

        // Undefined under stall is ignored; prime ExcCode to something distinguishable
        set_idle(); Undefined_D = 1'b1; Stall_D = 1'b1; PC_D = 32'h0040_0030; step();
        chk("stall_flush_d", 32'(obs_fd), 32'd0);
        chk("stall_pcsel", 32'(obs_pcsel), 32'd0);
        set_idle(); Cp0Addr_D = 5'd13; step(); chk("stall_cause", obs_rdata, 32'h30);
        Cp0Addr_D = 5'd14; step(); chk("stall_epc", obs_rdata, 32'h0040_0010);

        // Eret with same-cycle mtc0 to EPC
        set_idle(); Eret_D = 1'b1; Mtc0_W = 1'b1; Cp0Addr_W = 5'd14; Cp0Wdata_W = 32'h0040_0200; Cp0Addr_D = 5'd14; step();
        chk("eret_pcsel", 32'(obs_pcsel), 32'd2);
        chk("eret_excpc", obs_excpc, 32'h0040_0200);
        chk("eret_flush_d", 32'(obs_fd), 32'd1);
        chk("eret_flush_e", 32'(obs_fe), 32'd0);
        chk("eret_bypass", obs_rdata, 32'h0040_0200);
        set_idle(); step(); chk("eret_exl", 32'(obs_exl), 32'd0);

        // Interrupt: enable, then hold IntReq; taken two cycles after it rises
        set_idle(); Mtc0_W = 1'b1; Cp0Addr_W = 5'd12; Cp0Wdata_W = 32'd1; step();
        set_idle(); IntReq = 1'b1; PC_D = 32'h0040_0100;
        step(); chk("int_cyc0", 32'(obs_fe), 32'd0);
        step(); chk("int_cyc1", 32'(obs_fe), 32'd0);
        step(); chk("int_taken", {30'd0, obs_fd, obs_fe}, 32'd3);
        chk("int_pcsel", 32'(obs_pcsel), 32'd1);
        Cp0Addr_D = 5'd14; step(); chk("int_epc", obs_rdata, 32'h0040_0100);
        chk("int_masked", 32'(obs_fe), 32'd0);
        Cp0Addr_D = 5'd13; step(); chk("int_cause", obs_rdata, 32'h400);
        chk("int_masked2", 32'(obs_fe), 32'd0);

        // Nested exception preserves EPC
        set_idle(); Mtc0_W = 1'b1; Cp0Addr_W = 5'd14; Cp0Wdata_W = 32'h100; step();
        set_idle(); Undefined_D = 1'b1; PC_D = 32'h0040_0300; step();
        chk("nest_excpc", obs_excpc, 32'h180);
        chk("nest_pcsel", 32'(obs_pcsel), 32'd1);
        set_idle(); Cp0Addr_D = 5'd14; step(); chk("nest_epc", obs_rdata, 32'h100);
        Cp0Addr_D = 5'd13; step(); chk("nest_cause", obs_rdata, 32'h28);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            Overflow_E  = ($urandom_range(0, 9) == 0);
            Undefined_D = ($urandom_range(0, 7) == 0);
            Eret_D      = ($urandom_range(0, 5) == 0);
            Stall_D     = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) IntReq = ~IntReq;
            PC_D        = $urandom;
            PC_E        = $urandom;
            Cp0Addr_D   = pick_addr();
            Mtc0_W      = ($urandom_range(0, 3) == 0);
            Cp0Addr_W   = pick_addr();
            Cp0Wdata_W  = $urandom;
            if ($urandom_range(0, 3) != 0) Cp0Wdata_W[0] = 1'b1;
            step();
        end

        // Reset asserted in the middle of an overflow flush
        set_idle(); Overflow_E = 1'b1; PC_E = 32'h0040_0400;
        @(negedge clk);
        chk("midrst_pre_flush_m", 32'(Flush_M), 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_flush", {29'd0, Flush_D, Flush_E, Flush_M}, 32'd0);
        chk("midrst_pcsel", 32'(PCSel_Exc), 32'd0);
        chk("midrst_excpc", ExcPC, 32'd0);
        chk("midrst_exl", 32'(Exl), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        set_idle();
        rst = 1'b0;
        model_reset();
        Cp0Addr_D = 5'd12; step(); chk("post_rst_status", obs_rdata, 32'd0);
        Cp0Addr_D = 5'd13; step(); chk("post_rst_cause",  obs_rdata, 32'd0);
        Cp0Addr_D = 5'd14; step(); chk("post_rst_epc",    obs_rdata, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/exception_ctrl.md
# exception_ctrl

Coprocessor-0 exception controller for the 5-stage MIPS pipeline. It sits beside the hazard unit and consumes that unit's `Stall_D`. Where the hazard unit inserts stalls and bubbles for data dependencies, this block takes faults and interrupts. It holds the Status, Cause and EPC registers, raises pipeline flushes and selects the redirect PC for exception entry and `eret` return.

## Interface
Parameters:
- `HANDLER_ADDR`, default 32'h0000_0180: exception vector.
- `SYNC_STAGES`, default 2: interrupt synchronizer depth; must be at least 2.

Ports:
- `clk`: in, 1. Rising-edge clock.
- `rst`: in, 1. Asynchronous, active-high reset.
- `IntReq`: in, 1. External interrupt, level, asynchronous.
- `Overflow_E`: in, 1. Arithmetic overflow in Execute.
- `Undefined_D`: in, 1. Reserved opcode in Decode.
- `Eret_D`: in, 1. `eret` in Decode.
- `Stall_D`: in, 1. Decode stall from the hazard unit.
- `PC_D`, `PC_E`: in, 32. PC of the instruction in Decode and in Execute.
- `Cp0Addr_D`: in, 5. `mfc0` source register number.
- `Mtc0_W`: in, 1. `mtc0` write enable in Writeback.
- `Cp0Addr_W`: in, 5. `mtc0` destination register number.
- `Cp0Wdata_W`: in, 32. `mtc0` write data.
- `Flush_D`, `Flush_E`, `Flush_M`: out, 1 each. Clear IF/ID, ID/EX and EX/MEM respectively.
- `PCSel_Exc`: out, 2. 0 = normal, 1 = handler, 2 = EPC.
- `ExcPC`: out, 32. Redirect target; valid when `PCSel_Exc` is nonzero.
- `Cp0Rdata_D`: out, 32. `mfc0` read data.
- `Exl`: out, 1. Status.EXL.

## Operation
Registers:
- Status (reg 12): bit0 IE, bit1 EXL; other bits read 0.
- Cause (reg 13): bits[6:2] ExcCode, bit10 IP2 (synchronized `IntReq`, read-only); other bits read 0.
- EPC (reg 14): 32 bits.
- All other register numbers read 0 and ignore writes.

Event priority per cycle is Overflow_E, then Undefined_D, then interrupt, then Eret_D.
- **Overflow_E**:
  - flush D, E and M;
  - `PCSel_Exc`=1;
  - at the edge: ExcCode←12; EPC←PC_E if EXL=0; EXL←1.
- **Undefined_D**, taken only when `Stall_D`=0:
  - flush D and E;
  - `PCSel_Exc`=1;
  - at the edge: ExcCode←10; EPC←PC_D if EXL=0; EXL←1.
- **Interrupt**, taken when IP2=1, IE=1, EXL=0 and `Stall_D`=0:
  - flush D and E;
  - at the edge: ExcCode←0, EPC←PC_D, EXL←1;
  - the Decode instruction re-executes after return.
- **Eret_D**, taken when `Stall_D`=0:
  - flush D;
  - `PCSel_Exc`=2 with `ExcPC`=EPC;
  - at the edge: EXL←0.

Masking and suppression:
- EXL=1 masks interrupts only. Synchronous exceptions are still taken, but EPC is preserved.
- Undefined_D, interrupt and Eret_D are suppressed whenever Overflow_E is taken in the same cycle.

`mtc0` and `mfc0`:
- `mtc0` writes occur at the edge ending Writeback.
- An exception-entry update in the same cycle has priority over the `mtc0` write on EXL, ExcCode and EPC.
- IE remains writable by `mtc0` in that cycle.
- `mfc0` read is combinational.
- Write-to-read bypass: if `Mtc0_W` is set and `Cp0Addr_W` equals `Cp0Addr_D`, `Cp0Rdata_D` returns `Cp0Wdata_W`.
- `Eret_D` with `mtc0` to EPC in the same cycle: `ExcPC`=`Cp0Wdata_W`.

Interrupt synchronizer:
- `SYNC_STAGES` flops; the last stage drives IP2.

Control FSM:
- States NORMAL and IN_HANDLER, encoded by EXL.
- NORMAL→IN_HANDLER on any exception or interrupt taken.
- IN_HANDLER→NORMAL on `eret` taken or `mtc0` clearing EXL.

## Timing
- Flushes, `PCSel_Exc`, `ExcPC` and `Cp0Rdata_D` are combinational in the detection cycle. The handler fetch starts the next cycle.
- CP0 registers update on the rising edge that ends the detection cycle.
- Interrupt latency: `SYNC_STAGES` cycles from `IntReq` rise to IP2=1, plus wait until `Stall_D`=0.
- Deassertion of `IntReq` before it is taken drops the request; no latching.
- Reset, asynchronous, at any time:
  - Status, Cause, EPC and all sync flops clear to 0;
  - all flushes 0, `PCSel_Exc`=0, `ExcPC`=0, `Exl`=0;
  - this holds even mid-flush.
- While `rst` is high, outputs hold their reset values regardless of inputs.

## Structure
- Shared package `cp0_pkg`:
  - register numbers `CP0_STATUS`=12, `CP0_CAUSE`=13, `CP0_EPC`=14;
  - ExcCode constants `EXC_INT`=0, `EXC_RI`=10, `EXC_OV`=12;
  - `PCSel_Exc` encodings `PCSEL_NORMAL`/`PCSEL_HANDLER`/`PCSEL_EPC`.
- One sub-module, `sync_flops`, parameterized by depth, for the `IntReq` synchronizer.
- Priority logic and CP0 registers stay in `exception_ctrl`.

## Test plan
- **Overflow entry**: `Overflow_E`=1 with `PC_E`=32'h0040_0010 and EXL=0 → Flush_D, Flush_E and Flush_M high, `PCSel_Exc`=1, `ExcPC`=32'h180. Next cycle: EPC=32'h0040_0010, Cause[6:2]=12, Exl=1.
- **Priority and stall gating**: Overflow_E and Undefined_D together → only Overflow taken, ExcCode=12. `Undefined_D` with `Stall_D`=1 → no flush, no register change.
- **Interrupt**: `mtc0` Status=1, then `IntReq` held high → taken exactly 2 cycles later (`Stall_D`=0) with EPC=`PC_D`, ExcCode=0. A second `IntReq` while EXL=1 is ignored.
- **Nested exception**: while EXL=1 with EPC=32'h100, `Undefined_D` → redirect to 32'h180, ExcCode=10, EPC stays 32'h100.
- **Eret with EPC bypass**: `Eret_D` with `mtc0` to EPC (32'h0040_0200) in the same cycle → `PCSel_Exc`=2, `ExcPC`=32'h0040_0200, Flush_D=1; next cycle Exl=0.
- **Reset mid-flush**: assert `rst` during an active overflow flush → all outputs 0 immediately; after release, `mfc0` of regs 12, 13 and 14 returns 0.
